seq_detector_param: RTL and testbench

//  Parametrised Mealy serial-pattern detector, successor to the fixed 1010 detector.

---
 rtl/seq_det_pkg.sv | 22 ++
 rtl/seq_detector_param_sat_counter.sv | 30 +++
 rtl/seq_detector_param.sv | 98 +++++++++
 tb/tb_seq_detector_param.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared definitions for the parametrised serial-pattern detector.
package seq_det_pkg;

   // Largest pattern length any detector instance may be built for.
   localparam int SEQ_MAX_W_LIMIT = 16;

   // Overlap mode selected out of reset.
   localparam logic DEF_OVERLAP = 1'b1;

   // Reset pattern length: the full width of the instance.
   function automatic int def_len(input int max_w);
      return max_w;
   endfunction

   // Mask with the low 'len' bits set, i.e. (1 << len) - 1.
   function automatic logic [SEQ_MAX_W_LIMIT-1:0] len_mask(input logic [4:0] len);
      logic [SEQ_MAX_W_LIMIT:0] full;
      full = ({{SEQ_MAX_W_LIMIT{1'b0}}, 1'b1} << len) - {{SEQ_MAX_W_LIMIT{1'b0}}, 1'b1};
      return full[SEQ_MAX_W_LIMIT-1:0];
   endfunction

endpackage

// File: rtl/seq_detector_param_sat_counter.sv
// Saturating up-counter; a clear in the same cycle as an increment wins.
module sat_counter #(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] q
);

   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [CNT_W-1:0] cnt_r;

   // Count increments, hold at all-ones, clear has priority.
   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CNT_W{1'b0}};
      end else if (inc && (cnt_r != CNT_MAX)) begin
         cnt_r <= cnt_r + CNT_ONE;
      end
   end

   assign q = cnt_r;

endmodule

// File: rtl/seq_detector_param.sv
// Run-time configurable Mealy serial-pattern detector with a saturating
// match counter. Bit 0 of the pattern is the most recently received bit.
module seq_detector_param
   import seq_det_pkg::*;
#(
   parameter int MAX_W = 8,
   parameter int CNT_W = 8
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic                         cfg_load,
   input  logic [MAX_W-1:0]             cfg_pattern,
   input  logic [$clog2(MAX_W+1)-1:0]   cfg_len,
   input  logic                         cfg_overlap,
   input  logic                         din_valid,
   input  logic                         din,
   input  logic                         cnt_clr,
   output logic                         match,
   output logic [CNT_W-1:0]             match_cnt,
   output logic                         cfg_err
);

   localparam int LEN_W = $clog2(MAX_W+1);
   localparam logic [LEN_W-1:0] DEF_LEN_V = LEN_W'(def_len(MAX_W));
   localparam logic [LEN_W-1:0] MIN_LEN   = LEN_W'(2);
   localparam logic [LEN_W-1:0] FILL_MAX  = LEN_W'(MAX_W-1);
   localparam logic [LEN_W-1:0] LEN_ONE   = LEN_W'(1);

   logic [MAX_W-1:0] pattern_r;
   logic [LEN_W-1:0] len_r;
   logic             overlap_r;
   logic [MAX_W-2:0] window_r;
   logic [LEN_W-1:0] fill_r;
   logic             cfg_err_r;

   logic [MAX_W-1:0] cand_s;
   logic [MAX_W-1:0] mask_s;
   logic             len_ok_s;
   logic             match_s;

   // Candidate word, active-length mask, config legality and the match decision.
   always_comb begin
      cand_s   = {window_r, din};
      mask_s   = MAX_W'(len_mask(5'(len_r)));
      len_ok_s = (cfg_len >= MIN_LEN) && (cfg_len <= DEF_LEN_V);
      if (din_valid && !cfg_load && (fill_r >= (len_r - LEN_ONE)) &&
          ((cand_s & mask_s) == (pattern_r & mask_s))) begin
         match_s = 1'b1;
      end else begin
         match_s = 1'b0;
      end
   end

   // Config capture, history window shift and fill tracking.
   always_ff @(posedge clk) begin
      if (rst) begin
         pattern_r <= {MAX_W{1'b0}};
         len_r     <= DEF_LEN_V;
         overlap_r <= DEF_OVERLAP;
         window_r  <= {(MAX_W-1){1'b0}};
         fill_r    <= {LEN_W{1'b0}};
         cfg_err_r <= 1'b0;
      end else if (cfg_load) begin
         // A load always swallows any bit presented in the same cycle.
         if (len_ok_s) begin
            pattern_r <= cfg_pattern;
            len_r     <= cfg_len;
            overlap_r <= cfg_overlap;
            window_r  <= {(MAX_W-1){1'b0}};
            fill_r    <= {LEN_W{1'b0}};
         end else begin
            cfg_err_r <= 1'b1;
         end
      end else if (din_valid) begin
         window_r <= cand_s[MAX_W-2:0];
         // Non-overlapping mode forgets the matched bits by restarting the fill.
         if (match_s && !overlap_r) begin
            fill_r <= {LEN_W{1'b0}};
         end else if (fill_r < FILL_MAX) begin
            fill_r <= fill_r + LEN_ONE;
         end
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_cnt (
      .clk (clk),
      .rst (rst),
      .inc (match_s),
      .clr (cnt_clr),
      .q   (match_cnt)
   );

   assign match   = match_s;
   assign cfg_err = cfg_err_r;

endmodule

// File: tb/tb_seq_detector_param.sv
// Self-checking bench for seq_detector_param: a bit-history reference model
// predicts match per driven cycle into a scoreboard queue; two instances
// (8-bit and 2-bit counters) share the stimulus.
module tb_seq_detector_param;

   localparam int MAX_W = 8;
   localparam int LEN_W = $clog2(MAX_W+1);

   logic             clk = 1'b0;
   logic             rst;
   logic             cfg_load;
   logic [MAX_W-1:0] cfg_pattern;
   logic [LEN_W-1:0] cfg_len;
   logic             cfg_overlap;
   logic             din_valid;
   logic             din;
   logic             cnt_clr;
   logic             match, match_b;
   logic [7:0]       match_cnt;
   logic [1:0]       match_cnt_b;
   logic             cfg_err, cfg_err_b;

   int checks = 0;
   int errors = 0;
   int nbit   = 0;
   int seen   = 0;
   string tag = "init";

   bit   exp_q[$];
   bit   hist[$];
   logic [7:0] m_pat;
   int   m_len;
   bit   m_ovl;
   bit   m_err;
   int   m_cnt_a;
   int   m_cnt_b;

   always #5 clk = ~clk;

   seq_detector_param #(.MAX_W(MAX_W), .CNT_W(8)) dut_a (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
      .din(din), .cnt_clr(cnt_clr), .match(match), .match_cnt(match_cnt),
      .cfg_err(cfg_err)
   );

   seq_detector_param #(.MAX_W(MAX_W), .CNT_W(2)) dut_b (
      .clk(clk), .rst(rst), .cfg_load(cfg_load), .cfg_pattern(cfg_pattern),
      .cfg_len(cfg_len), .cfg_overlap(cfg_overlap), .din_valid(din_valid),
      .din(din), .cnt_clr(cnt_clr), .match(match_b), .match_cnt(match_cnt_b),
      .cfg_err(cfg_err_b)
   );

   // One clock of stimulus: model predicts, scoreboard compares.
   task automatic cycle(input bit v, input bit d, input bit ld, input logic [7:0] pat,
                        input int len, input bit ovl, input bit clr);
      bit exp_m;
      bit ok;
      bit got_exp;
      @(negedge clk);
      din_valid   = v;
      din         = d;
      cfg_load    = ld;
      cfg_pattern = pat;
      cfg_len     = LEN_W'(len);
      cfg_overlap = ovl;
      cnt_clr     = clr;
      exp_m = 1'b0;
      if (v && !ld) begin
         nbit++;
         hist.push_back(d);
         if (hist.size() > 16) void'(hist.pop_front());
         if (hist.size() >= m_len) begin
            ok = 1'b1;
            for (int i = 0; i < m_len; i++)
               if (hist[hist.size()-1-i] != m_pat[i]) ok = 1'b0;
            exp_m = ok;
         end
         if (exp_m && !m_ovl) hist.delete();
      end
      if (ld) begin
         if (len >= 2 && len <= MAX_W) begin
            m_pat = pat; m_len = len; m_ovl = ovl; hist.delete();
         end else begin
            m_err = 1'b1;
         end
      end
      if (clr) begin
         m_cnt_a = 0; m_cnt_b = 0;
      end else if (exp_m) begin
         if (m_cnt_a < 255) m_cnt_a++;
         if (m_cnt_b < 3) m_cnt_b++;
      end
      exp_q.push_back(exp_m);
      #2;
      got_exp = exp_q.pop_front();
      if (match === 1'b1) seen++;
      checks++;
      if (match !== got_exp) begin
         errors++;
         $display("FAIL %s match bit %0d: got %b expected %b", tag, nbit, match, got_exp);
      end
      checks++;
      if (match_b !== got_exp) begin
         errors++;
         $display("FAIL %s match_b bit %0d: got %b expected %b", tag, nbit, match_b, got_exp);
      end
      @(posedge clk);
      #1;
      checks++;
      if (match_cnt !== 8'(m_cnt_a)) begin
         errors++;
         $display("FAIL %s match_cnt bit %0d: got %0d expected %0d", tag, nbit, match_cnt, m_cnt_a);
      end
      checks++;
      if (match_cnt_b !== 2'(m_cnt_b)) begin
         errors++;
         $display("FAIL %s match_cnt_b bit %0d: got %0d expected %0d", tag, nbit, match_cnt_b, m_cnt_b);
      end
      checks++;
      if (cfg_err !== m_err || cfg_err_b !== m_err) begin
         errors++;
         $display("FAIL %s cfg_err: got %b/%b expected %b", tag, cfg_err, cfg_err_b, m_err);
      end
      din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
   endtask

   task automatic send(input bit d);
      cycle(1'b1, d, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic gap();
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b0);
   endtask

   task automatic load(input logic [7:0] pat, input int len, input bit ovl);
      cycle(1'b0, 1'b0, 1'b1, pat, len, ovl, 1'b0);
   endtask

   task automatic clear_cnt();
      cycle(1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      seen = 0;
   endtask

   task automatic apply_reset();
      @(negedge clk);
      rst = 1'b1; din_valid = 1'b0; cfg_load = 1'b0; cnt_clr = 1'b0;
      @(posedge clk);
      #1;
      rst = 1'b0;
      hist.delete();
      m_pat = 8'h00; m_len = MAX_W; m_ovl = 1'b1; m_err = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
   endtask

   task automatic test_reset();
      tag = "reset";
      apply_reset();
      checks++;
      if (match_cnt !== 8'd0 || match_cnt_b !== 2'd0) begin
         errors++;
         $display("FAIL reset count: got %0d/%0d expected 0", match_cnt, match_cnt_b);
      end
      checks++;
      if (cfg_err !== 1'b0 || match !== 1'b0) begin
         errors++;
         $display("FAIL reset flags: got err %b match %b expected 0 0", cfg_err, match);
      end
   endtask

   task automatic test_overlap();
      tag = "overlap";
      load(8'h0A, 4, 1'b1);
      clear_cnt();
      for (int i = 0; i < 8; i++) send(~i[0]);
      checks++;
      if (match_cnt !== 8'd3 || seen != 3) begin
         errors++;
         $display("FAIL overlap total: got cnt %0d seen %0d expected 3", match_cnt, seen);
      end
   endtask

   task automatic test_non_overlap();
      tag = "non_overlap";
      load(8'h0A, 4, 1'b0);
      clear_cnt();
      for (int i = 0; i < 8; i++) send(~i[0]);
      checks++;
      if (match_cnt !== 8'd2 || seen != 2) begin
         errors++;
         $display("FAIL non_overlap total: got cnt %0d seen %0d expected 2", match_cnt, seen);
      end
   endtask

   task automatic test_gaps();
      tag = "gaps";
      load(8'h07, 3, 1'b1);
      clear_cnt();
      for (int i = 0; i < 5; i++) begin
         send(1'b1);
         gap();
         gap();
      end
      checks++;
      if (match_cnt !== 8'd3 || seen != 3) begin
         errors++;
         $display("FAIL gaps total: got cnt %0d seen %0d expected 3", match_cnt, seen);
      end
   endtask

   task automatic test_saturate();
      tag = "saturate";
      load(8'h03, 2, 1'b1);
      clear_cnt();
      for (int i = 0; i < 9; i++) send(1'b1);
      checks++;
      if (match_cnt_b !== 2'd3 || match_cnt !== 8'd8) begin
         errors++;
         $display("FAIL saturate: got %0d/%0d expected 3/8", match_cnt_b, match_cnt);
      end
      tag = "clr_on_match";
      cycle(1'b1, 1'b1, 1'b0, 8'h00, 0, 1'b0, 1'b1);
      checks++;
      if (match_cnt_b !== 2'd0 || match_cnt !== 8'd0) begin
         errors++;
         $display("FAIL clr_on_match: got %0d/%0d expected 0/0", match_cnt_b, match_cnt);
      end
   endtask

   task automatic test_cfg();
      tag = "cfg_err";
      load(8'h0A, 4, 1'b1);
      load(8'h01, 1, 1'b1);
      clear_cnt();
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
      checks++;
      if (cfg_err !== 1'b1 || seen != 1) begin
         errors++;
         $display("FAIL cfg_err old pattern: got err %b seen %0d expected 1 1", cfg_err, seen);
      end
      tag = "load_collision";
      send(1'b1); send(1'b0); send(1'b1);
      cycle(1'b1, 1'b0, 1'b1, 8'h0A, 4, 1'b1, 1'b0);
      send(1'b0);
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
   endtask

   task automatic test_reset_midstream();
      tag = "reset_mid";
      load(8'h0A, 4, 1'b1);
      send(1'b1); send(1'b0); send(1'b1);
      apply_reset();
      seen = 0;
      send(1'b0);
      for (int i = 0; i < 7; i++) send(1'b0);
      checks++;
      if (match_cnt !== 8'd1 || seen != 1) begin
         errors++;
         $display("FAIL reset_mid default len: got cnt %0d seen %0d expected 1", match_cnt, seen);
      end
      tag = "after_reset";
      load(8'h0A, 4, 1'b1);
      send(1'b1); send(1'b0); send(1'b1); send(1'b0);
   endtask

   initial begin
      rst = 1'b1; cfg_load = 1'b0; cfg_pattern = '0; cfg_len = '0;
      cfg_overlap = 1'b0; din_valid = 1'b0; din = 1'b0; cnt_clr = 1'b0;
      m_pat = 8'h00; m_len = MAX_W; m_ovl = 1'b1; m_err = 1'b0;
      m_cnt_a = 0; m_cnt_b = 0;
      test_reset();
      test_overlap();
      test_non_overlap();
      test_gaps();
      test_saturate();
      test_cfg();
      test_reset_midstream();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
